// File: rtl/hazard_ctrl_p.sv
// Pipeline hazard/stall controller for a 5-stage datapath: load-use bubbles,
// memory waits, branch/jump flushes, sequenced halt drain and a wait watchdog.
module hazard_ctrl_p #(
  parameter int REG_AW       = 5,
  parameter int LU_BUBBLES   = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 0,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              exmem_dmemren,
  input  logic              exmem_dmemwen,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              idex_memtoreg,
  input  logic [REG_AW-1:0] idex_dest,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              halt_in,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_flush,
  output logic              halt_out,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WC_W-1:0] WC_TGT = WC_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, LU_STALL, DRAIN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [2:0]        lu_cnt_q, lu_cnt_d;
  logic [3:0]        dr_cnt_q, dr_cnt_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              halt_out_q, halt_out_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic dmem_wait;
  logic load_use;

  assign dmem_wait = (exmem_dmemren | exmem_dmemwen) & ~dhit;
  assign load_use  = idex_memtoreg & (idex_dest != '0) &
                     ((idex_dest == ifid_rs) | (ifid_uses_rt & (idex_dest == ifid_rt)));

  always_comb begin
    state_d       = state_q;
    lu_cnt_d      = lu_cnt_q;
    dr_cnt_d      = dr_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    halt_out_d    = halt_out_q;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    memwb_flush   = 1'b0;

    if (RST || state_q == HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (dmem_wait) begin
      // Freeze everything up to MEM; the WB latch receives a bubble.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (branch_taken && state_q != DRAIN) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_d  = LU_STALL;
              lu_cnt_d = 3'(LU_BUBBLES - 1);
            end
          end else if (jump) begin
            ifid_flush = 1'b1;
          end else if (halt_in) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            state_d    = DRAIN;
            dr_cnt_d   = 4'(DRAIN_CYCLES);
          end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        LU_STALL: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          if (lu_cnt_q <= 3'd1) state_d = RUN;
          else                  lu_cnt_d = lu_cnt_q - 3'd1;
        end
        DRAIN: begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          // The last drain cycle hands over to HALTED on its closing edge.
          if (dr_cnt_q <= 4'd1) begin
            state_d    = HALTED;
            halt_out_d = 1'b1;
          end else begin
            dr_cnt_d = dr_cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end

    if (state_q != HALTED && dmem_wait) begin
      if (MEM_TIMEOUT != 0 && wait_cnt_q == WC_TGT) mem_timeout_d = 1'b1;
      if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = '0;
    end

    if (!pc_en && state_q != HALTED && !RST && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= RUN;
      lu_cnt_q      <= '0;
      dr_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      halt_out_q    <= 1'b0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      lu_cnt_q      <= lu_cnt_d;
      dr_cnt_q      <= dr_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      halt_out_q    <= halt_out_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign halt_out    = halt_out_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Scoreboard bench for hazard_ctrl_p: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_hazard_ctrl_p;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, exmem_dmemren, exmem_dmemwen;
  logic [4:0]  ifid_rs, ifid_rt, idex_dest;
  logic        ifid_uses_rt, idex_memtoreg, branch_taken, jump, halt_in;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_flush;
  logic        halt_out, mem_timeout;
  logic [15:0] stall_cnt;

  always #5 CLK = ~CLK;

  hazard_ctrl_p #(
    .REG_AW(5), .LU_BUBBLES(2), .DRAIN_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_dmemren(exmem_dmemren), .exmem_dmemwen(exmem_dmemwen),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_memtoreg(idex_memtoreg), .idex_dest(idex_dest),
    .branch_taken(branch_taken), .jump(jump), .halt_in(halt_in),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .halt_out(halt_out), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt)
  );

  // Control vector order: pc, ifid, idex, exmem, memwb enables, then ifid/idex/memwb flushes.
  localparam logic [7:0] C_RST  = 8'b00000_000;
  localparam logic [7:0] C_RUN  = 8'b11111_000;
  localparam logic [7:0] C_LU   = 8'b00111_010;
  localparam logic [7:0] C_DW   = 8'b00001_001;
  localparam logic [7:0] C_BR   = 8'b11111_110;
  localparam logic [7:0] C_JMP  = 8'b11111_100;
  localparam logic [7:0] C_HOLD = 8'b01111_100;
  localparam logic [7:0] C_HLT  = 8'b00000_000;

  typedef struct {
    string      nm;
    logic [7:0] ctl;
    logic       h;
    logic       t;
    int         st;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic idle();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b1; exmem_dmemren = 1'b0; exmem_dmemwen = 1'b0;
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0; idex_memtoreg = 1'b0;
    idex_dest = 5'd0; branch_taken = 1'b0; jump = 1'b0; halt_in = 1'b0;
  endtask

  task automatic lu_in(input logic [4:0] dest, input logic [4:0] rs);
    idle();
    idex_memtoreg = 1'b1; idex_dest = dest; ifid_rs = rs;
  endtask

  task automatic dwait();
    idle();
    exmem_dmemwen = 1'b1; dhit = 1'b0;
  endtask

  // st < 0 skips the registered outputs (unknown before the first edge).
  task automatic cyc(input string nm, input logic [7:0] ctl, input logic h,
                     input logic t, input int st);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.h = h; e.t = t; e.st = st;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL %s ctl: got %b expected %b", e.nm, act, e.ctl);
        end
        if (e.st >= 0) begin
          checks++;
          if (halt_out !== e.h) begin
            errors++;
            $display("FAIL %s halt_out: got %b expected %b", e.nm, halt_out, e.h);
          end
          checks++;
          if (mem_timeout !== e.t) begin
            errors++;
            $display("FAIL %s mem_timeout: got %b expected %b", e.nm, mem_timeout, e.t);
          end
          checks++;
          if (stall_cnt !== 16'(e.st)) begin
            errors++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.nm, stall_cnt, e.st);
          end
        end
        $display("check %s ctl=%b halt=%b tmo=%b stall=%0d", e.nm, act, halt_out, mem_timeout, stall_cnt);
      end
    end
  end

  initial begin : stim
    int budget;
    idle();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b1;                        cyc("rst0",        C_RST, 0, 0, -1);
    RST = 1'b1;                        cyc("rst1",        C_RST, 0, 0, 0);
    idle();                            cyc("idle",        C_RUN, 0, 0, 0);
    // Load-use, two bubbles.
    lu_in(5, 5);                       cyc("lu_b1",       C_LU,  0, 0, 0);
    lu_in(5, 5);                       cyc("lu_b2",       C_LU,  0, 0, 1);
    idle();                            cyc("lu_done",     C_RUN, 0, 0, 2);
    lu_in(0, 0);                       cyc("lu_dest0",    C_RUN, 0, 0, 2);
    lu_in(7, 1); ifid_rt = 7;          cyc("lu_rt_unused",C_RUN, 0, 0, 2);
    // Load-use on rt, dmem wait inside LU_STALL.
    lu_in(7, 1); ifid_rt = 7; ifid_uses_rt = 1; cyc("lu_rt_b1", C_LU, 0, 0, 2);
    lu_in(7, 1); ifid_rt = 7; ifid_uses_rt = 1; exmem_dmemren = 1; dhit = 0;
                                       cyc("lu_wait1",    C_DW,  0, 0, 3);
                                       cyc("lu_wait2",    C_DW,  0, 0, 4);
                                       cyc("lu_wait3",    C_DW,  0, 0, 5);
    dhit = 1'b1;                       cyc("lu_b2_after", C_LU,  0, 0, 6);
    idle();                            cyc("lu_wait_done",C_RUN, 0, 0, 7);
    // Branch beats halt and load-use.
    idle(); branch_taken = 1; halt_in = 1; cyc("br_halt",  C_BR,  0, 0, 7);
    idle();                            cyc("br_after",    C_RUN, 0, 0, 7);
    lu_in(5, 5);                       cyc("lu_pre_br",   C_LU,  0, 0, 7);
    lu_in(5, 5); branch_taken = 1;     cyc("br_in_lu",    C_BR,  0, 0, 8);
    idle();                            cyc("br_lu_run",   C_RUN, 0, 0, 8);
    idle(); jump = 1;                  cyc("jump",        C_JMP, 0, 0, 8);
    idle(); ihit = 0;                  cyc("no_ihit",     C_HOLD,0, 0, 8);
    idle(); ihit = 0; jump = 1;        cyc("jump_noihit", C_JMP, 0, 0, 9);
    lu_in(5, 5); jump = 1;             cyc("lu_over_jmp", C_LU,  0, 0, 9);
    idle();                            cyc("lu_stall2",   C_LU,  0, 0, 10);
    // Watchdog: 3 waits, gap, 3 waits must not fire; 4 waits must.
    dwait();                           cyc("wd_a1",       C_DW,  0, 0, 11);
                                       cyc("wd_a2",       C_DW,  0, 0, 12);
                                       cyc("wd_a3",       C_DW,  0, 0, 13);
    idle();                            cyc("wd_gap",      C_RUN, 0, 0, 14);
    dwait();                           cyc("wd_b1",       C_DW,  0, 0, 14);
                                       cyc("wd_b2",       C_DW,  0, 0, 15);
                                       cyc("wd_b3",       C_DW,  0, 0, 16);
    idle();                            cyc("wd_gap2",     C_RUN, 0, 0, 17);
    dwait();                           cyc("wd_c1",       C_DW,  0, 0, 17);
                                       cyc("wd_c2",       C_DW,  0, 0, 18);
                                       cyc("wd_c3",       C_DW,  0, 0, 19);
                                       cyc("wd_c4",       C_DW,  0, 0, 20);
    idle();                            cyc("wd_fired",    C_RUN, 0, 1, 21);
    // Halt drain with one wait cycle inside.
    idle(); halt_in = 1;               cyc("halt_acc",    C_HOLD,0, 1, 21);
    idle();                            cyc("drain1",      C_HOLD,0, 1, 22);
    dwait();                           cyc("drain_wait",  C_DW,  0, 1, 23);
    idle();                            cyc("drain2",      C_HOLD,0, 1, 24);
    idle();                            cyc("drain3",      C_HOLD,0, 1, 25);
    idle();                            cyc("halted",      C_HLT, 1, 1, 26);
    dwait(); branch_taken = 1; ihit = 0; cyc("halted_ign", C_HLT, 1, 1, 26);
    idle(); RST = 1;                   cyc("rst_halted",  C_RST, 1, 1, 26);
    idle();                            cyc("post_rst1",   C_RUN, 0, 0, 0);
    // Reset in the middle of DRAIN.
    idle(); halt_in = 1;               cyc("halt_acc2",   C_HOLD,0, 0, 0);
    idle();                            cyc("drain2_1",    C_HOLD,0, 0, 1);
    dwait(); halt_in = 1; RST = 1;     cyc("rst_drain",   C_RST, 0, 0, 2);
    idle();                            cyc("post_rst2",   C_RUN, 0, 0, 0);
    idle();                            cyc("post_rst3",   C_RUN, 0, 0, 0);

    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge CLK);
      budget--;
    end
    if (sb_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain_scoreboard: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : time_limit
    #200000;
    $display("FAIL time_limit: got timeout expected finish");
    $fatal(1, "time limit reached");
  end

endmodule
